// File: rtl/quad_gate_bist_seq.sv
// quad_gate_bist_seq: exhaustive self-test sequencer for a quad 2-input OR gate package.
// It applies all 256 A/B combinations, waits a settle time for each, checks the outputs
// against the OR truth table, and reports a mismatch count and a pass/fail verdict.
// Optional build macro: QUAD_GATE_BIST_FAIL_CAPTURE_EN adds first-mismatch capture outputs
// (fail_valid, fail_vec, fail_y).
module quad_gate_bist_seq #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          STOP_ON_FAIL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] dut_y,
    output logic [3:0] drv_a,
    output logic [3:0] drv_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic [7:0] vec
`ifdef QUAD_GATE_BIST_FAIL_CAPTURE_EN
    ,
    output logic       fail_valid,
    output logic [7:0] fail_vec,
    output logic [3:0] fail_y
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned VEC_W = 8;
    localparam int unsigned ERR_W = 9;
    localparam int unsigned Y_W   = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(255);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [VEC_W-1:0] vec_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic [Y_W-1:0]   drv_a_nxt, drv_b_nxt;
    logic [Y_W-1:0]   exp_c;
    logic             mismatch_c;
`ifdef QUAD_GATE_BIST_FAIL_CAPTURE_EN
    logic             fail_valid_nxt;
    logic [VEC_W-1:0] fail_vec_nxt;
    logic [Y_W-1:0]   fail_y_nxt;
`endif

    // Odd vector bits feed the A pins, even bits the B pins.
    function automatic logic [Y_W-1:0] vec_to_a(input logic [VEC_W-1:0] v);
        logic [Y_W-1:0] r;
        for (int i = 0; i < int'(Y_W); i++) r[i] = v[2*i+1];
        return r;
    endfunction

    function automatic logic [Y_W-1:0] vec_to_b(input logic [VEC_W-1:0] v);
        logic [Y_W-1:0] r;
        for (int i = 0; i < int'(Y_W); i++) r[i] = v[2*i];
        return r;
    endfunction

    // Expected OR response; X/Z on the gate outputs is treated as a mismatch.
    always_comb begin
        exp_c      = drv_a | drv_b;
        mismatch_c = (dut_y !== exp_c);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vec_nxt   = vec;
        err_nxt   = err_count;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        pass_nxt  = pass;
`ifdef QUAD_GATE_BIST_FAIL_CAPTURE_EN
        fail_valid_nxt = fail_valid;
        fail_vec_nxt   = fail_vec;
        fail_y_nxt     = fail_y;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    vec_nxt   = '0;
                    err_nxt   = '0;
                    pass_nxt  = 1'b0;
                    cnt_nxt   = SETTLE_LOAD;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_SETTLE;
`ifdef QUAD_GATE_BIST_FAIL_CAPTURE_EN
                    fail_valid_nxt = 1'b0;
                    fail_vec_nxt   = '0;
                    fail_y_nxt     = '0;
`endif
                end
            end
            ST_SETTLE: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch_c) begin
                    err_nxt = err_count + ERR_W'(1);
`ifdef QUAD_GATE_BIST_FAIL_CAPTURE_EN
                    if (!fail_valid) begin
                        fail_valid_nxt = 1'b1;
                        fail_vec_nxt   = vec;
                        fail_y_nxt     = dut_y;
                    end
`endif
                end
                if ((vec == VEC_LAST) || (STOP_ON_FAIL && mismatch_c)) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == '0);
                end else begin
                    vec_nxt   = vec + VEC_W'(1);
                    cnt_nxt   = SETTLE_LOAD;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        drv_a_nxt = vec_to_a(vec_nxt);
        drv_b_nxt = vec_to_b(vec_nxt);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            vec       <= '0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            drv_a     <= '0;
            drv_b     <= '0;
`ifdef QUAD_GATE_BIST_FAIL_CAPTURE_EN
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            fail_y     <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            vec       <= vec_nxt;
            err_count <= err_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            drv_a     <= drv_a_nxt;
            drv_b     <= drv_b_nxt;
`ifdef QUAD_GATE_BIST_FAIL_CAPTURE_EN
            fail_valid <= fail_valid_nxt;
            fail_vec   <= fail_vec_nxt;
            fail_y     <= fail_y_nxt;
`endif
        end
    end

endmodule
